stage_2_dispatch: RTL and testbench
===================================

# stage_2_dispatch

Downstream receiver for the first stage of the final adder. It captures each result bundle that stage 1 announces with its one-cycle `done` pulse: two CORDIC-format operands, two halved floats and two squared floats. It buffers bundles in a 2-entry FIFO, because stage 1 has no back-pressure. It runs the two operands of each bundle through one shared CORDIC core, one after the other, and presents the completed bundle to stage 3 with a valid/ready handshake.

## Interface
- `FLT_DATA_WIDTH`, 32, float width of the half/square fields.
- `CORDIC_DATA_WIDTH`, 22, fixed-point width of the CORDIC operand and result.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `clk_en`  in  1  global enable; when low, all registers hold, including the FIFO, FSM, sticky flag and outputs.
- `in_done`  in  1  stage-1 `done` pulse; the bundle below is valid while it is high.
- `in_one`, `in_two`  in  CORDIC_DATA_WIDTH  CORDIC operands.
- `in_half_one`, `in_half_two`, `in_square_one`, `in_square_two`  in  FLT_DATA_WIDTH  pass-through fields.
- `cordic_start`  out  1  one-cycle launch pulse to the CORDIC core.
- `cordic_angle`  out  CORDIC_DATA_WIDTH  operand; stable from the `cordic_start` cycle until `cordic_done` is sampled.
- `cordic_done`  in  1  CORDIC completion pulse.
- `cordic_result`  in  CORDIC_DATA_WIDTH  CORDIC output; valid while `cordic_done` is high.
- `out_valid`  out  1  completed bundle available.
- `out_ready`  in  1  stage 3 accepts the bundle.
- `cos_one`, `cos_two`  out  CORDIC_DATA_WIDTH  CORDIC results for lanes one and two.
- `half_one`, `half_two`, `square_one`, `square_two`  out  FLT_DATA_WIDTH  pass-through fields.
- `busy`  out  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky flag; set when a bundle is dropped.

## Operation
**Reset:** every output and register goes to 0. The FSM goes to IDLE and the FIFO count goes to 0.

**FIFO:**
- Depth 2; each entry holds all six input fields, 172 bits at the default widths.
- Push happens on an edge where `clk_en && in_done`.
- Pop happens on an edge where the FSM leaves IDLE.
- Push while full with no pop on the same edge: the bundle is dropped, contents are unchanged, and `overflow` is set to 1. `overflow` stays set until reset.
- Push and pop on the same edge: the push is accepted even when the FIFO is full, and the count is unchanged.
- Push while empty is never bypassed; the bundle is written to the FIFO first.
- No wrap-around corruption: two-bit count with wrapping read/write pointers.

**FSM** (advances only on edges with `clk_en` high):
- IDLE: if the count is greater than 0, pop the head into the working registers and go to L1.
- L1: `cordic_start`=1 and `cordic_angle`=working one. Go to W1 on the next edge.
- W1: on `cordic_done`, latch `cordic_result` into `cos_one`, then go to L2.
- L2: `cordic_start`=1 and `cordic_angle`=working two. Go to W2.
- W2: on `cordic_done`, latch the result into `cos_two`, copy the half/square fields to the outputs, set `out_valid`=1, then go to OUT.
- OUT: hold all outputs. When `out_valid && out_ready` is sampled, set `out_valid`=0 and go to IDLE.

**Other rules:**
- `cordic_done` is ignored in every state except W1 and W2.
- `cordic_start` is high only in L1 and L2.
- Output fields keep their last values after the handshake until they are overwritten by the next W2 completion.
- Reset asserted mid-operation returns every state and output to its reset value immediately, without waiting for a clock edge. The FIFO contents are discarded, and any CORDIC run in progress is abandoned. After reset, any `cordic_done` that arrives is ignored, because the FSM is in IDLE.

## Timing
- Latency without back-pressure, taking E0 as the edge that samples `in_done` with an empty FIFO and an idle FSM:
  - E1 pops the bundle.
  - `cordic_start` is high from E1 to E2.
  - With a CORDIC that raises `cordic_done` L cycles after the start cycle, `out_valid` rises at edge E(3+2L).
- Throughput is one bundle per 2L+4 cycles, since an accepted bundle spends one cycle in IDLE before the next pop.
- Stage 1 may pulse `in_done` at most every 2 cycles. The FIFO absorbs up to two bundles beyond the one in flight.
- With `clk_en` low, edges are not counted: the latency is extended by exactly the number of disabled cycles. `in_done` or `cordic_done` pulses seen during disabled cycles are lost.

## Test plan
- **Single bundle:** `in_one`=0x012345, `in_two`=0x054321, CORDIC model with L=3 returning angle XOR 0x3FFFFF, `out_ready`=1. Required: `out_valid` rises at E9, with `cos_one`=0x3EDCBA and `cos_two`=0x3ABCDE. The four float fields must equal their inputs bit-exact, and `busy` falls at E11.
- **Back-to-back:** three `in_done` pulses 2 cycles apart. Required: three outputs in order, `overflow`=0, and the FIFO count peaks at 2.
- **Overflow:** L=20, five pulses 2 cycles apart. Required: bundles 1-3 are delivered, bundles 4 and 5 are dropped, and `overflow`=1 from the edge that drops bundle 4 until reset.
- **Full FIFO with simultaneous pop:** fill the FIFO to 2 entries, then push on the same edge the FSM pops. Required: the push is accepted and `overflow` stays 0.
- **Back-pressure and clk_en:** hold `out_ready`=0 for 10 cycles, then drop `clk_en` for 4 cycles mid-W1. Required: outputs are stable throughout the stall, and the latency grows by exactly 4.
- **Reset mid-W2:** pulse `rst` low asynchronously while in W2 with a FIFO count of 1. Required: all outputs read 0 at once, and a later `cordic_done` produces no `out_valid`.

Source files
------------

// File: rtl/stage_2_dispatch.sv
// stage_2_dispatch: buffers stage-1 result bundles in a 2-entry FIFO, runs both
// operands of each bundle through a shared CORDIC core and hands the completed
// bundle to stage 3 over a valid/ready handshake.
module stage_2_dispatch #(
  parameter int unsigned FLT_DATA_WIDTH    = 32,
  parameter int unsigned CORDIC_DATA_WIDTH = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         in_done,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_two,
  input  logic [FLT_DATA_WIDTH-1:0]    in_half_one,
  input  logic [FLT_DATA_WIDTH-1:0]    in_half_two,
  input  logic [FLT_DATA_WIDTH-1:0]    in_square_one,
  input  logic [FLT_DATA_WIDTH-1:0]    in_square_two,
  output logic                         cordic_start,
  output logic [CORDIC_DATA_WIDTH-1:0] cordic_angle,
  input  logic                         cordic_done,
  input  logic [CORDIC_DATA_WIDTH-1:0] cordic_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CORDIC_DATA_WIDTH-1:0] cos_one,
  output logic [CORDIC_DATA_WIDTH-1:0] cos_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_two,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned FW = FLT_DATA_WIDTH;
  localparam int unsigned CW = CORDIC_DATA_WIDTH;
  localparam int unsigned PW = 4 * FW;     // half/square pass-through fields
  localparam int unsigned WW = CW + PW;    // working copy: operand two + pass-through
  localparam int unsigned EW = CW + WW;    // full FIFO entry

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_W1   = 3'd2,
    S_L2   = 3'd3,
    S_W2   = 3'd4,
    S_OUT  = 3'd5
  } state_e;

  state_e          state_q, state_d;

  logic [EW-1:0]   fifo_q [2];
  logic [1:0]      cnt_q, cnt_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic            overflow_q;
  logic [EW-1:0]   entry_c, head_c;
  logic            pop_c, push_ok_c, drop_c;

  logic [WW-1:0]   work_q, work_d;
  logic            start_q, start_d;
  logic [CW-1:0]   angle_q, angle_d;
  logic [CW-1:0]   cos_one_q, cos_one_d;
  logic [CW-1:0]   cos_two_q, cos_two_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            valid_q, valid_d;
  logic            busy_q;

  assign entry_c = {in_one, in_two, in_half_one, in_half_two, in_square_one, in_square_two};
  assign head_c  = fifo_q[rd_ptr_q];

  // FIFO occupancy: a push alongside a pop always fits, otherwise a full FIFO drops it
  always_comb begin
    push_ok_c = in_done && ((cnt_q != 2'd2) || pop_c);
    drop_c    = in_done && !push_ok_c;
    cnt_d     = cnt_q;
    if (push_ok_c && !pop_c) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_ok_c && pop_c) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Next-state and next-output logic for the dispatch sequencer
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    work_d    = work_q;
    start_d   = 1'b0;
    angle_d   = angle_q;
    cos_one_d = cos_one_q;
    cos_two_d = cos_two_q;
    pass_d    = pass_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 2'd0) begin
          pop_c   = 1'b1;
          work_d  = head_c[WW-1:0];
          start_d = 1'b1;
          angle_d = head_c[EW-1 -: CW];
          state_d = S_L1;
        end
      end
      S_L1: state_d = S_W1;
      S_W1: begin
        if (cordic_done) begin
          cos_one_d = cordic_result;
          start_d   = 1'b1;
          angle_d   = work_q[WW-1 -: CW];
          state_d   = S_L2;
        end
      end
      S_L2: state_d = S_W2;
      S_W2: begin
        if (cordic_done) begin
          cos_two_d = cordic_result;
          pass_d    = work_q[PW-1:0];
          valid_d   = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // FIFO storage, pointers, count and sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clk_en) begin
      if (push_ok_c) begin
        fifo_q[wr_ptr_q] <= entry_c;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Working bundle and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q    <= '0;
      start_q   <= 1'b0;
      angle_q   <= '0;
      cos_one_q <= '0;
      cos_two_q <= '0;
      pass_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (clk_en) begin
      work_q    <= work_d;
      start_q   <= start_d;
      angle_q   <= angle_d;
      cos_one_q <= cos_one_d;
      cos_two_q <= cos_two_d;
      pass_q    <= pass_d;
      valid_q   <= valid_d;
      busy_q    <= (state_q != S_IDLE) || (cnt_q != 2'd0);
    end
  end

  assign cordic_start = start_q;
  assign cordic_angle = angle_q;
  assign out_valid    = valid_q;
  assign cos_one      = cos_one_q;
  assign cos_two      = cos_two_q;
  assign half_one     = pass_q[3*FW +: FW];
  assign half_two     = pass_q[2*FW +: FW];
  assign square_one   = pass_q[FW +: FW];
  assign square_two   = pass_q[0 +: FW];
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_stage_2_dispatch.sv
// tb_stage_2_dispatch: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (bundle queue + per-bundle edge counts).
module tb_stage_2_dispatch;

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 22;
  localparam logic [CW-1:0] MASK = 22'h3FFFFF;

  typedef struct {
    logic [CW-1:0] one;
    logic [CW-1:0] two;
    logic [FW-1:0] h1;
    logic [FW-1:0] h2;
    logic [FW-1:0] s1;
    logic [FW-1:0] s2;
  } bundle_t;

  logic          clk, rst, clk_en, in_done, out_ready;
  logic          cordic_start, cordic_done, out_valid, busy, overflow;
  logic [CW-1:0] in_one, in_two, cordic_angle, cordic_result, cos_one, cos_two;
  logic [FW-1:0] in_half_one, in_half_two, in_square_one, in_square_two;
  logic [FW-1:0] half_one, half_two, square_one, square_two;
  bundle_t       drv;

  assign in_one        = drv.one;
  assign in_two        = drv.two;
  assign in_half_one   = drv.h1;
  assign in_half_two   = drv.h2;
  assign in_square_one = drv.s1;
  assign in_square_two = drv.s2;

  stage_2_dispatch #(.FLT_DATA_WIDTH(FW), .CORDIC_DATA_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_done(in_done),
    .in_one(in_one), .in_two(in_two),
    .in_half_one(in_half_one), .in_half_two(in_half_two),
    .in_square_one(in_square_one), .in_square_two(in_square_two),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_done(cordic_done), .cordic_result(cordic_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .cos_one(cos_one), .cos_two(cos_two),
    .half_one(half_one), .half_two(half_two),
    .square_one(square_one), .square_two(square_two),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int dut_hs = 0;
  int L      = 3;

  // Reference model: pending bundles, bundle in flight, enabled edges since its pop
  bundle_t       mq[$];
  bundle_t       m_cur, m_outb;
  bit            m_inflight, m_valid, m_busy, m_ovf;
  int            m_k;
  logic [CW-1:0] m_cos1, m_cos2;

  // CORDIC responder: result = angle ^ MASK, done L enabled cycles after the start cycle
  int            r_cnt = 0;
  logic [CW-1:0] r_angle;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_inflight = 0; m_valid = 0; m_busy = 0; m_ovf = 0; m_k = 0;
    m_outb = '{default: '0};
    m_cur  = '{default: '0};
    m_cos1 = '0; m_cos2 = '0;
  endtask

  task automatic rand_bundle();
    drv.one = CW'($urandom);
    drv.two = CW'($urandom);
    drv.h1  = $urandom;
    drv.h2  = $urandom;
    drv.s1  = $urandom;
    drv.s2  = $urandom;
  endtask

  // One clock: snapshot what the edge samples, advance responder and model, compare
  task automatic step();
    logic          s_rst, s_en, s_done, s_ready, s_start, s_valid;
    logic [CW-1:0] s_angle;
    bundle_t       s_b;
    int            sz;
    bit            pop, busy_new, exp_start;
    s_rst = rst; s_en = clk_en; s_done = in_done; s_ready = out_ready;
    s_start = cordic_start; s_valid = out_valid; s_angle = cordic_angle; s_b = drv;
    @(posedge clk);
    #1;
    cyc++;
    if (s_en) begin
      if (r_cnt > 0) r_cnt--;
      if (s_start) begin
        r_cnt   = L;
        r_angle = s_angle;
      end
      cordic_done   = (r_cnt == 1);
      cordic_result = r_angle ^ MASK;
    end
    if (s_rst && s_en) begin
      if (s_valid && s_ready) dut_hs++;
      sz       = mq.size();
      busy_new = m_inflight || (sz != 0);
      pop      = !m_inflight && (sz != 0);
      if (m_inflight) begin
        if (m_valid) begin
          if (s_ready) begin
            m_inflight = 0;
            m_valid    = 0;
          end
        end else begin
          m_k++;
          if (m_k == L + 1) m_cos1 = m_cur.one ^ MASK;
          if (m_k == 2 * L + 2) begin
            m_valid = 1;
            m_outb  = m_cur;
            m_cos2  = m_cur.two ^ MASK;
          end
        end
      end
      if (pop) begin
        m_cur      = mq.pop_front();
        m_inflight = 1;
        m_k        = 0;
      end
      if (s_done) begin
        if (sz < 2 || pop) mq.push_back(s_b);
        else m_ovf = 1;
      end
      m_busy = busy_new;
    end
    exp_start = m_inflight && !m_valid && (m_k == 0 || m_k == L + 1);
    chk("out_valid", out_valid, m_valid);
    chk("cordic_start", cordic_start, exp_start);
    if (exp_start) chk("cordic_angle", cordic_angle, (m_k == 0) ? m_cur.one : m_cur.two);
    chk("busy", busy, m_busy);
    chk("overflow", overflow, m_ovf);
    chk("cos_one", cos_one, m_cos1);
    chk("cos_two", cos_two, m_cos2);
    chk("half_one", half_one, m_outb.h1);
    chk("half_two", half_two, m_outb.h2);
    chk("square_one", square_one, m_outb.s1);
    chk("square_two", square_two, m_outb.s2);
    @(negedge clk);
  endtask

  task automatic push_bundle();
    rand_bundle();
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_done = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
    while ((m_inflight || mq.size() != 0 || r_cnt != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 64'(n), 64'(0));
  endtask

  // Reset pulsed between clock edges; outputs must clear without an edge
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cordic_start", cordic_start, 0);
    chk("rst_cordic_angle", cordic_angle, 0);
    chk("rst_cos_one", cos_one, 0);
    chk("rst_cos_two", cos_two, 0);
    chk("rst_half_one", half_one, 0);
    chk("rst_square_two", square_two, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    int e0, n, hs0, last;
    rst = 1'b0; clk_en = 1'b1; in_done = 1'b0; out_ready = 1'b1;
    cordic_done = 1'b0; cordic_result = '0; r_angle = '0;
    drv = '{default: '0};
    model_clear();
    step();
    step();
    rst = 1'b1;
    step();

    // Single bundle, L=3
    L = 3;
    rand_bundle();
    drv.one = 22'h012345;
    drv.two = 22'h054321;
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    e0 = cyc;
    n = 0;
    while (!out_valid && n < 60) begin step(); n++; end
    chk("single_valid_edge", 64'(cyc - e0), 64'(9));
    chk("single_cos_one", cos_one, 22'h3EDCBA);
    chk("single_cos_two", cos_two, 22'h3ABCDE);
    chk("single_half_one", half_one, drv.h1);
    chk("single_square_two", square_two, drv.s2);
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    chk("single_busy_fall_edge", 64'(cyc - e0), 64'(11));
    drain(100);

    // Back-to-back: three pulses two cycles apart
    hs0 = dut_hs;
    for (int i = 0; i < 3; i++) push_bundle();
    drain(200);
    chk("b2b_delivered", 64'(dut_hs - hs0), 64'(3));
    chk("b2b_overflow", overflow, 0);

    // Overflow: L=20, five pulses, bundles 4 and 5 dropped
    L = 20;
    hs0 = dut_hs;
    for (int i = 0; i < 5; i++) push_bundle();
    chk("ovf_flag", overflow, 1);
    drain(400);
    chk("ovf_delivered", 64'(dut_hs - hs0), 64'(3));
    chk("ovf_sticky", overflow, 1);
    async_reset();
    step();

    // Full FIFO with a push on the pop edge (pushes at E0,E2,E4,E11; pop at E11)
    L = 3;
    hs0 = dut_hs;
    for (int i = 0; i < 3; i++) push_bundle();
    for (int i = 0; i < 5; i++) step();
    rand_bundle();
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    chk("simul_pop_start", cordic_start, 1);
    chk("simul_overflow", overflow, 0);
    drain(300);
    chk("simul_delivered", 64'(dut_hs - hs0), 64'(4));

    // Back-pressure and clk_en stall mid-W1
    out_ready = 1'b0;
    rand_bundle();
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    e0 = cyc;
    step();
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    clk_en = 1'b1;
    n = 0;
    while (!out_valid && n < 60) begin step(); n++; end
    chk("stall_valid_edge", 64'(cyc - e0), 64'(13));
    for (int i = 0; i < 10; i++) step();
    chk("stall_valid_held", out_valid, 1);
    drain(100);

    // Reset mid-W2 with one bundle queued; the late cordic_done must be ignored
    hs0 = dut_hs;
    push_bundle();
    push_bundle();
    for (int i = 0; i < 4; i++) step();
    async_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) n++;
    end
    chk("post_rst_no_valid", 64'(n), 64'(0));
    chk("post_rst_delivered", 64'(dut_hs - hs0), 64'(0));

    // Randomized traffic
    for (int ph = 0; ph < 3; ph++) begin
      L = int'($urandom_range(1, 6));
      last = -10;
      for (int c = 0; c < 300; c++) begin
        clk_en    = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        if ((cyc + 1 - last) >= 2 && $urandom_range(0, 2) == 0) begin
          rand_bundle();
          in_done = 1'b1;
          last = cyc + 1;
        end else begin
          in_done = 1'b0;
        end
        step();
      end
      drain(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
